// File: rtl/if_id_buffer_pkg.sv
// Shared IF/ID pipeline types: buffer state, fetch bundle layout and the
// instruction reset value.
package if_id_buffer_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   // Reference layout at default widths; the top re-declares it per IW/AW.
   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] pc;
      logic        intr;
   } if_id_bundle_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_id_entry.sv
// One bundle register with a valid bit: load writes data and sets valid,
// clear drops valid (clear wins over load for the valid bit).
module if_id_entry
   import if_id_buffer_pkg::*;
#(
   parameter int           W       = $bits(if_id_bundle_t),
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         valid
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q     <= RST_VAL;
         valid <= 1'b0;
      end else begin
         if (load) q <= d;
         if (clear)     valid <= 1'b0;
         else if (load) valid <= 1'b1;
      end
   end

endmodule

// File: rtl/if_id_buffer.sv
// IF->ID pipeline buffer with flush and saturating drop counter.
// IF_ID_SKID_EN: 2-entry skid buffer with registered in_ready; otherwise depth 1.
module if_id_buffer
   import if_id_buffer_pkg::*;
#(
   parameter int IW    = 32,
   parameter int AW    = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IW-1:0]    in_instruction,
   input  logic [AW-1:0]    in_pc,
   input  logic             in_int,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IW-1:0]    out_instruction,
   output logic [AW-1:0]    out_pc,
   output logic             out_int,
   output logic [CNT_W-1:0] drop_count
);

   typedef struct packed {
      logic [IW-1:0] instruction;
      logic [AW-1:0] pc;
      logic          intr;
   } bundle_t;

   localparam bundle_t RST_BUNDLE = '{instruction: IW'(NOP_INSTR), pc: '0, intr: 1'b0};

   state_e         state;
   bundle_t        in_b, m_d, m_q;
   logic           m_vld, m_load, m_clr;
   logic           in_xfer, out_xfer;
   logic [1:0]     n_drop;
   logic [CNT_W:0] drop_sum;

   assign in_b      = '{instruction: in_instruction, pc: in_pc, intr: in_int};
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = m_vld & out_ready;
   assign out_valid = m_vld;
   assign out_instruction = m_q.instruction;
   assign out_pc    = m_q.pc;
   assign out_int   = m_q.intr;
   assign drop_sum  = {1'b0, drop_count} + (CNT_W+1)'(n_drop);

   if_id_entry #(.W($bits(bundle_t)), .RST_VAL(RST_BUNDLE)) u_m (
      .clk(clk), .rst_n(rst_n), .load(m_load), .clear(m_clr),
      .d(m_d), .q(m_q), .valid(m_vld)
   );

`ifdef IF_ID_SKID_EN
   bundle_t s_q;
   logic    s_vld, s_load, s_clr;

   if_id_entry #(.W($bits(bundle_t)), .RST_VAL(RST_BUNDLE)) u_s (
      .clk(clk), .rst_n(rst_n), .load(s_load), .clear(s_clr),
      .d(in_b), .q(s_q), .valid(s_vld)
   );

   assign in_ready = (state != ST_TWO);
   assign m_d      = (state == ST_TWO) ? s_q : in_b;

   always_comb begin
      m_load = 1'b0;
      m_clr  = flush;
      s_load = 1'b0;
      s_clr  = flush;
      n_drop = 2'd0;
      case (state)
         ST_EMPTY: m_load = ~flush & in_xfer;
         ST_ONE: begin
            m_load = ~flush & in_xfer & out_xfer;
            m_clr  = flush | (out_xfer & ~in_xfer);
            s_load = ~flush & in_xfer & ~out_xfer;
            n_drop = out_xfer ? 2'd0 : 2'd1;
         end
         ST_TWO: begin
            m_load = ~flush & out_xfer;
            s_clr  = flush | out_xfer;
            n_drop = out_xfer ? 2'd1 : 2'd2;
         end
         default: ;
      endcase
   end
`else
   assign in_ready = out_ready | ~m_vld;
   assign m_d      = in_b;
   assign m_load   = ~flush & in_xfer;
   assign m_clr    = flush | (out_xfer & ~in_xfer);
   assign n_drop   = {1'b0, m_vld & ~out_ready};
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_EMPTY;
         drop_count <= '0;
      end else if (flush) begin
         state      <= ST_EMPTY;
         drop_count <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end else begin
         case (state)
            ST_EMPTY: if (in_xfer) state <= ST_ONE;
`ifdef IF_ID_SKID_EN
            ST_ONE: begin
               if (in_xfer && !out_xfer)      state <= ST_TWO;
               else if (!in_xfer && out_xfer) state <= ST_EMPTY;
            end
            ST_TWO: if (out_xfer) state <= ST_ONE;
`else
            ST_ONE: if (!in_xfer && out_xfer) state <= ST_EMPTY;
`endif
            default: state <= ST_EMPTY;
         endcase
      end
   end

endmodule
